// File: rtl/shift_left_2.sv
// Branch-offset shifter: combinational In << SHIFT plus a registered copy
// carrying valid and overflow flags for pipelined datapaths.
module shift_left_2 #(
  parameter int WIDTH = 64,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] out_reg,
  output logic             out_valid,
  output logic             overflow
);

  logic [WIDTH-1:0] shifted;
  logic             lost_bits;

  // Bit-level wiring keeps the shift purely structural, so X/Z on In
  // reaches Out bit for bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi < SHIFT) begin : g_zero
        assign shifted[gi] = 1'b0;
      end else begin : g_pass
        assign shifted[gi] = In[gi-SHIFT];
      end
    end
  endgenerate

  assign lost_bits = |In[WIDTH-1:WIDTH-SHIFT];
  assign Out       = shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_reg   <= shifted;
      overflow  <= lost_bits;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_left_2.sv
// Scoreboard bench for shift_left_2: combinational sweep, boundaries,
// registered capture, overflow, asynchronous reset and streaming.
module tb_shift_left_2;

  localparam int WIDTH = 64;

  typedef struct {
    logic [WIDTH-1:0] val;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_reg;
  logic             out_valid;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] last_reg = '0;
  logic             last_ovf = 1'b0;

  shift_left_2 #(.WIDTH(WIDTH), .SHIFT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .In       (in_data),
    .in_valid (in_valid),
    .Out      (out_data),
    .out_reg  (out_reg),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational step: apply In, look 1 time unit later.
  task automatic comb_step(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    in_data = d;
    #1;
    $display("t=%0t In=%b Out=%b", $time, in_data, out_data);
    check("comb_out", out_data, exp);
    #4;
  endtask

  // One clocked transaction; called 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
    exp_t e;
    in_data  = d;
    in_valid = v;
    if (v) begin
      e.val = d << 2;
      e.ovf = |d[WIDTH-1:WIDTH-2];
      sb_q.push_back(e);
    end
    #1;
    check("cyc_comb_out", out_data, d << 2);
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cyc_valid", {63'd0, out_valid}, 64'd1);
      check("cyc_out_reg", out_reg, e.val);
      check("cyc_overflow", {63'd0, overflow}, {63'd0, e.ovf});
      last_reg = e.val;
      last_ovf = e.ovf;
    end else begin
      check("hold_valid", {63'd0, out_valid}, 64'd0);
      check("hold_out_reg", out_reg, last_reg);
      check("hold_overflow", {63'd0, overflow}, {63'd0, last_ovf});
    end
    $display("t=%0t in_valid=%0d In=%h out_reg=%h out_valid=%0d overflow=%0d",
             $time, v, d, out_reg, out_valid, overflow);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Combinational sweep while held in reset
    comb_step(64'd2, 64'd8);
    comb_step(64'd4, 64'd16);
    comb_step(64'd8, 64'd32);
    comb_step(64'd16, 64'd64);
    comb_step(64'd0, 64'd0);
    comb_step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC);
    comb_step(64'h4000_0000_0000_0000, 64'd0);
    comb_step(64'h3FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC);

    check("rst_out_reg", out_reg, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single capture then idle
    cycle(1'b1, 64'd5);
    check("pulse_out_reg", out_reg, 64'd20);
    check("pulse_valid", {63'd0, out_valid}, 64'd1);
    cycle(1'b0, 64'd9);
    check("idle_out_reg", out_reg, 64'd20);
    check("idle_valid", {63'd0, out_valid}, 64'd0);

    // Overflow flag set then cleared
    cycle(1'b1, 64'h8000_0000_0000_0001);
    check("ovf_out_reg", out_reg, 64'd4);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    cycle(1'b1, 64'd1);
    check("noovf_out_reg", out_reg, 64'd4);
    check("noovf_flag", {63'd0, overflow}, 64'd0);

    // Mid-stream asynchronous reset
    cycle(1'b1, 64'hC000_0000_0000_0007);
    in_valid = 1'b0;
    #2;
    rst_n   = 1'b0;
    in_data = 64'd3;
    #1;
    check("arst_out_reg", out_reg, 64'd0);
    check("arst_overflow", {63'd0, overflow}, 64'd0);
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_comb_out", out_data, 64'd12);
    $display("t=%0t reset asserted out_reg=%h out_valid=%0d Out=%h",
             $time, out_reg, out_valid, out_data);
    last_reg = '0;
    last_ovf = 1'b0;
    @(posedge clk);
    #1;
    in_data = 64'h0000_0000_0000_0100;
    #1;
    check("arst_hold_out_reg", out_reg, 64'd0);
    check("arst_comb_out2", out_data, 64'h0000_0000_0000_0400);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    // Streaming, one word per clock
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 64'(i));
      check("stream_out_reg", out_reg, 64'(4 * i));
    end
    cycle(1'b0, 64'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_left_2.md
# shift_left_2

Branch-offset shifter for the LEGv8 datapath: multiplies a 64-bit unsigned word by 4 with a logical left shift by two. It sits between sign-extend and the branch-target adder. The block has two output paths. One is a zero-latency combinational path used directly by the single-cycle datapath. The other is a registered copy with valid and overflow flags, used by pipelined variants.

## Interface
- WIDTH, 64, data width in bits (≥ 3)
- SHIFT, 2, fixed left-shift amount (1 ≤ SHIFT < WIDTH)

- clk  input  1  rising-edge clock for the registered path
- rst_n  input  1  asynchronous, active-low reset
- In  input  WIDTH  unsigned operand
- in_valid  input  1  qualifies In for capture into the registered path
- Out  output  WIDTH  combinational result, In << SHIFT
- out_reg  output  WIDTH  registered result
- out_valid  output  1  out_reg holds a captured result
- overflow  output  1  registered flag: a 1 bit was shifted out of the top of the last captured operand

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Out = {In[WIDTH-1-SHIFT:0], SHIFT'b0}.
  - Pure logical shift; the low SHIFT bits are always 0.
  - The top SHIFT bits of In are discarded.
  - No sign handling: operands are unsigned.
- Out depends only on In. It ignores clk, rst_n and in_valid, including while the block is held in reset.
- Registered path, on each rising clk edge with rst_n high:
  - in_valid=1: out_reg ← In << SHIFT; overflow ← |In[WIDTH-1:WIDTH-SHIFT]; out_valid ← 1.
  - in_valid=0: out_reg and overflow hold; out_valid ← 0.
- The result is truncated to WIDTH bits (arithmetic mod 2^WIDTH). overflow is the only indication that truncation occurred.
- X or Z on In propagates to Out bitwise. There is no X-masking.

## Timing
- Out: zero cycles, combinational, settles within the same delta/time step as In. A bench sampling 1 time unit after an In change must see the new value.
- out_reg, overflow, out_valid: one-cycle latency from the in_valid edge.
- Back-to-back in_valid captures every cycle. Throughput is one word per clock, with no backpressure.
- Reset (rst_n=0, asynchronous assert): out_reg=0, overflow=0, out_valid=0 immediately, independent of clk.
- Reset deassertion is synchronised externally. The first capture happens on the first rising edge with rst_n=1 and in_valid=1.
- Reset asserted mid-stream: the pending registered result is lost and out_valid drops at once. Out keeps tracking In.
- In changing without in_valid: Out follows it; the registered outputs do not change.

## Test plan
- Combinational sweep, no clock: In=2 → Out=8; In=4 → Out=16; In=8 → Out=32; In=16 → Out=64. Change In every 5 time units and check Out at each step. Dump waves and print time/In/Out in binary.
- Boundary values:
  - In=0 → Out=0.
  - In=64'hFFFF_FFFF_FFFF_FFFF → Out=64'hFFFF_FFFF_FFFF_FFFC.
  - In=64'h4000_0000_0000_0000 → Out=0.
  - In=64'h3FFF_FFFF_FFFF_FFFF → Out=64'hFFFF_FFFF_FFFF_FFFC.
- Registered path:
  - With rst_n=1, pulse in_valid for one cycle with In=5 → next cycle out_reg=20, out_valid=1, overflow=0.
  - The following cycle (in_valid=0): out_valid=0 and out_reg remains 20.
- Overflow flag:
  - Capture In=64'h8000_0000_0000_0001 → out_reg=4, overflow=1.
  - Then capture In=1 → out_reg=4, overflow=0.
- Reset:
  - Assert rst_n=0 between clock edges while out_valid=1 → out_reg=0, overflow=0, out_valid=0 before the next edge.
  - Out still equals In<<2 throughout the reset window.
- Streaming: apply in_valid=1 for 4 consecutive cycles with In=1,2,3,4 → out_reg=4,8,12,16 on the 4 following edges, with out_valid held at 1.
